// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch with one outstanding memory request and a 2-entry {pc, inst} buffer.
// Optional IFETCH_MISALIGN_EXC_EN adds misalign_o, flagging a flush to a non-word-aligned target.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
`ifdef IFETCH_MISALIGN_EXC_EN
    ,
    output logic        misalign_o
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t state, state_nx;
    logic [1:0] occ, occ_nx, wr;
    logic armed, push, pop;
    logic [31:0] pc, pc_nx, addr_nx;
    logic [31:0] e0_pc, e0_inst, e1_pc, e1_inst;
    assign valid_o = occ != 2'd0;
    assign pc_o    = valid_o ? e0_pc : 32'h0;
    assign inst_o  = valid_o ? e0_inst : 32'h0;
    assign pop     = valid_o && !stall_i && !flush_i;
    assign push    = state == BUSY && mem_ack_i && !flush_i;
    // wr is the slot a push lands in once this cycle's pop has shifted the buffer
    assign wr      = occ - {1'b0, pop};
    assign occ_nx  = flush_i ? 2'd0 : wr + {1'b0, push};
    assign pc_nx   = flush_i ? {flush_pc_i[31:2], 2'b00} : push ? pc + 32'd4 : pc;
    assign addr_nx = state_nx == BUSY ? pc_nx : mem_addr_o;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ((flush_i || armed) && occ_nx != 2'd2) ? BUSY : IDLE;
            BUSY:    state_nx = mem_ack_i ? (occ_nx != 2'd2 ? BUSY : IDLE) : (flush_i ? DRAIN : BUSY);
            DRAIN:   state_nx = mem_ack_i ? BUSY : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    // armed holds off the first request by one cycle after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            occ        <= 2'd0;
            pc         <= RESET_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= RESET_PC;
            e0_pc      <= 32'h0;
            e0_inst    <= 32'h0;
            e1_pc      <= 32'h0;
            e1_inst    <= 32'h0;
        end else begin
            state      <= state_nx;
            armed      <= 1'b1;
            occ        <= occ_nx;
            pc         <= pc_nx;
            mem_req_o  <= state_nx != IDLE;
            mem_addr_o <= addr_nx;
            e0_pc      <= (push && wr == 2'd0) ? mem_addr_o : pop ? e1_pc : e0_pc;
            e0_inst    <= (push && wr == 2'd0) ? mem_data_i : pop ? e1_inst : e0_inst;
            e1_pc      <= (push && wr == 2'd1) ? mem_addr_o : e1_pc;
            e1_inst    <= (push && wr == 2'd1) ? mem_data_i : e1_inst;
        end
    end
`ifdef IFETCH_MISALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_o <= 1'b0;
        else      misalign_o <= flush_i && flush_pc_i[1:0] != 2'b00;
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of inst_fetch; covers misalign_o when IFETCH_MISALIGN_EXC_EN is defined.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, mem_ack_i;
    logic [31:0] flush_pc_i, mem_data_i;
    logic        mem_req_o, valid_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;
`ifdef IFETCH_MISALIGN_EXC_EN
    logic        misalign_o;
`endif
    int vectors = 0;
    int miscompares = 0;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
`ifdef IFETCH_MISALIGN_EXC_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
        cyc(); cyc();
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0h exp 0", mem_req_o); end
        vectors++; if (mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %0h exp 0", mem_addr_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0h exp 0", valid_o); end
        vectors++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin miscompares++; $display("FAIL rst_nop got pc %0h inst %0h exp 0 0", pc_o, inst_o); end
        rst = 1'b1;
        cyc();
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL first_edge_req got %0h exp 0", mem_req_o); end
        cyc();
        vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL second_edge_req got %0h/%0h exp 1/0", mem_req_o, mem_addr_o); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            mem_ack_i = 1'b1; mem_data_i = mem_word(mem_addr_o);
            cyc();
            vectors++;
            if (valid_o !== 1'b1 || pc_o !== 32'(i * 4) || inst_o !== mem_word(32'(i * 4)) || mem_req_o !== 1'b1 || mem_addr_o !== 32'((i + 1) * 4)) begin
                miscompares++;
                $display("FAIL stream[%0d] got v=%0h pc=%0h inst=%0h req=%0h addr=%0h exp v=1 pc=%0h inst=%0h req=1 addr=%0h",
                         i, valid_o, pc_o, inst_o, mem_req_o, mem_addr_o, i * 4, mem_word(32'(i * 4)), (i + 1) * 4);
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ack_i = 1'b1; mem_data_i = mem_word(mem_addr_o);
            cyc();
            vectors++;
            if (valid_o !== 1'b1 || pc_o !== 32'd28 || mem_req_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall[%0d] got v=%0h pc=%0h req=%0h exp v=1 pc=1c req=0", i, valid_o, pc_o, mem_req_o);
            end
        end
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack_i = mem_req_o; mem_data_i = mem_word(mem_addr_o);
            cyc();
            vectors++;
            if (valid_o !== 1'b1 || pc_o !== 32'(32 + i * 4) || inst_o !== mem_word(32'(32 + i * 4))) begin
                miscompares++;
                $display("FAIL resume[%0d] got v=%0h pc=%0h inst=%0h exp v=1 pc=%0h", i, valid_o, pc_o, inst_o, 32 + i * 4);
            end
        end
        vectors++; if (mem_addr_o !== 32'd48) begin miscompares++; $display("FAIL resume_addr got %0h exp 30", mem_addr_o); end
    endtask

    task automatic test_late_flush();
        mem_ack_i = 1'b0;
        cyc();
        vectors++; if (valid_o !== 1'b0 || mem_req_o !== 1'b1) begin miscompares++; $display("FAIL late_wait got v=%0h req=%0h exp 0/1", valid_o, mem_req_o); end
        flush_i = 1'b1; flush_pc_i = 32'h100;
        cyc();
        flush_i = 1'b0;
        vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd48 || valid_o !== 1'b0) begin miscompares++; $display("FAIL drain_hold got req=%0h addr=%0h v=%0h exp 1/30/0", mem_req_o, mem_addr_o, valid_o); end
        cyc();
        mem_ack_i = 1'b1; mem_data_i = mem_word(32'd48);
        cyc();
        vectors++; if (valid_o !== 1'b0 || mem_addr_o !== 32'h100) begin miscompares++; $display("FAIL drain_discard got v=%0h addr=%0h exp 0/100", valid_o, mem_addr_o); end
        mem_data_i = mem_word(32'h100);
        cyc();
        mem_ack_i = 1'b0;
        vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== mem_word(32'h100)) begin miscompares++; $display("FAIL late_redirect got v=%0h pc=%0h inst=%0h exp 1/100", valid_o, pc_o, inst_o); end
    endtask

    task automatic test_flush_ack();
        stall_i = 1'b1;
        flush_i = 1'b1; flush_pc_i = 32'h40; mem_ack_i = 1'b1; mem_data_i = mem_word(mem_addr_o);
        cyc();
        flush_i = 1'b0;
        vectors++; if (valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin miscompares++; $display("FAIL flush_ack got v=%0h req=%0h addr=%0h exp 0/1/40", valid_o, mem_req_o, mem_addr_o); end
        mem_data_i = mem_word(32'h40);
        cyc();
        mem_ack_i = 1'b0;
        vectors++; if (valid_o !== 1'b1 || pc_o !== 32'h40 || inst_o !== mem_word(32'h40)) begin miscompares++; $display("FAIL flush_ack_next got v=%0h pc=%0h inst=%0h exp 1/40", valid_o, pc_o, inst_o); end
        stall_i = 1'b0;
    endtask

    task automatic test_wrap();
        flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFE; mem_ack_i = 1'b0;
        cyc();
        flush_i = 1'b0;
        vectors++; if (mem_addr_o !== 32'h44 || valid_o !== 1'b0) begin miscompares++; $display("FAIL wrap_drain got addr=%0h v=%0h exp 44/0", mem_addr_o, valid_o); end
`ifdef IFETCH_MISALIGN_EXC_EN
        vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL misalign_pulse got %0h exp 1", misalign_o); end
`endif
        mem_ack_i = 1'b1; mem_data_i = mem_word(32'h44);
        cyc();
`ifdef IFETCH_MISALIGN_EXC_EN
        vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL misalign_end got %0h exp 0", misalign_o); end
`endif
        vectors++; if (mem_addr_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_aligned got %0h exp fffffffc", mem_addr_o); end
        mem_data_i = mem_word(32'hFFFF_FFFC);
        cyc();
        vectors++; if (mem_addr_o !== 32'h0 || pc_o !== 32'hFFFF_FFFC || valid_o !== 1'b1) begin miscompares++; $display("FAIL wrap_addr got addr=%0h pc=%0h v=%0h exp 0/fffffffc/1", mem_addr_o, pc_o, valid_o); end
        mem_data_i = mem_word(32'h0);
        cyc();
        vectors++; if (pc_o !== 32'h0 || inst_o !== mem_word(32'h0) || mem_addr_o !== 32'h4) begin miscompares++; $display("FAIL wrap_next got pc=%0h inst=%0h addr=%0h exp 0/%0h/4", pc_o, inst_o, mem_addr_o, mem_word(32'h0)); end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        #1;
        vectors++; if (mem_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'h0 || mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL async_rst got req=%0h v=%0h pc=%0h addr=%0h exp 0/0/0/0", mem_req_o, valid_o, pc_o, mem_addr_o); end
        @(negedge clk);
        rst = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        cyc();
        vectors++; if (valid_o !== 1'b0 || mem_req_o !== 1'b0) begin miscompares++; $display("FAIL late_ack1 got v=%0h req=%0h exp 0/0", valid_o, mem_req_o); end
        cyc();
        vectors++; if (valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin miscompares++; $display("FAIL late_ack2 got v=%0h req=%0h addr=%0h exp 0/1/0", valid_o, mem_req_o, mem_addr_o); end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_late_flush();
        test_flush_ack();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
